tile_cfg_loader: RTL and testbench
==================================

TILE_CFG_LOADER -- requirements
Module: tile_cfg_loader

Interface
REQ-001 SHALL have parameter NUM_TILES, default 4, number of tiles on the configuration bus.
REQ-002 SHALL have parameter CFG_W, default 77, configuration bits per tile.
REQ-003 SHALL have parameter WORD_W, default 8, width of input stream word.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  begin a configuration load (sampled in IDLE only).
REQ-007 SHALL have port abort  input  1  abandon current load, return to IDLE.
REQ-008 SHALL have port s_valid  input  1  stream word valid.
REQ-009 SHALL have port s_data  input  WORD_W  stream word, LSB-first bit order.
REQ-010 SHALL have port s_last  input  1  marks final word of the whole load.
REQ-011 SHALL have port s_ready  output  1  loader accepts word this cycle.
REQ-012 SHALL have port wr_en  output  NUM_TILES  one-hot per-tile configuration write strobe.
REQ-013 SHALL have port bits  output  CFG_W  shared configuration bus to all tiles.
REQ-014 SHALL have port busy  output  1  high in any state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-016 SHALL have port err  output  1  framing error, sticky until abort or reset.

Function
REQ-017 SHALL define WPT = ceil(CFG_W/WORD_W) words per tile; bits of the final word above CFG_W are discarded.
REQ-018 SHALL implement states IDLE, LOAD, WRITE, DONE, ERR.
REQ-019 IDLE: start=1 and abort=0 -> LOAD next cycle; word counter, tile counter and shadow register cleared.
REQ-020 LOAD: s_ready=1; word accepted when s_valid&&s_ready; accepted word written into shadow at bit offset word_cnt*WORD_W.
REQ-021 LOAD: acceptance of word WPT-1 -> WRITE next cycle, s_ready=0 from that cycle.
REQ-022 WRITE: exactly one cycle; wr_en[tile_cnt]=1, all other wr_en bits 0; bits equals completed shadow during WRITE and the following cycle.
REQ-023 WRITE exit: tile_cnt==NUM_TILES-1 -> DONE; else tile_cnt+1, word_cnt=0, shadow zeroed, -> LOAD.
REQ-024 DONE: done=1 for one cycle, -> IDLE.
REQ-025 s_last=1 on any accepted word other than word WPT-1 of tile NUM_TILES-1 -> ERR next cycle, no wr_en for that tile.
REQ-026 s_last=0 on word WPT-1 of tile NUM_TILES-1 -> ERR next cycle, no wr_en for that tile.
REQ-027 ERR: err=1, s_ready=0, wr_en=0; held until abort=1, then IDLE.
REQ-028 abort=1 in any state -> IDLE next cycle, overrides all other transitions; a partly filled tile is never written.
REQ-029 start while not in IDLE SHALL be ignored; abort and start together in IDLE -> stay IDLE.
REQ-030 s_data/s_last SHALL be ignored when s_valid=0 or s_ready=0; s_valid may stall arbitrarily without data loss.
REQ-031 wr_en SHALL never have more than one bit set, and SHALL be 0 outside WRITE.

Reset
REQ-032 rst_n=0 SHALL asynchronously force IDLE, counters 0, shadow 0, s_ready=0, wr_en=0, bits=0, busy=0, done=0, err=0.
REQ-033 Reset asserted mid-load SHALL produce no wr_en pulse; load restarts only on a new start after rst_n release.

Structure
REQ-034 State enum and a ceiling-divide function SHALL live in shared package tile_cfg_pkg.
REQ-035 Word packing into the shadow register SHALL be a sub-module tile_cfg_shadow (clear, write-enable, word index in; CFG_W shadow out).

Verification (defaults: NUM_TILES=4, CFG_W=77, WORD_W=8, WPT=10)
REQ-036 start then 40 words, s_last on word 40, s_valid continuous -> wr_en 0001,0010,0100,1000 each one cycle, bits match each tile's 77-bit frame, done pulses once, err=0.
REQ-037 Final word of tile 0 = 8'hFF -> bits[76:72]=5'b11111, upper 3 bits discarded, no bits above 76 affected.
REQ-038 s_valid toggling every other cycle over full load -> identical wr_en sequence and bits to REQ-036, only later in time.
REQ-039 s_last on word 15 -> err=1 next cycle, only wr_en[0] ever pulsed; abort -> IDLE, err=0, busy=0.
REQ-040 abort during word 5 of tile 2 -> IDLE next cycle, wr_en[2] never asserted; rst_n low during tile 1 -> all outputs 0 immediately.
REQ-041 start pulsed during LOAD of tile 1 -> no effect; done pulses exactly once at end.

Source files
------------

// File: rtl/tile_cfg_pkg.sv
// Shared types and sizing helpers for the tile configuration loader.
package tile_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  // Counter width that stays at least one bit for single-entry ranges.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tile_cfg_shadow.sv
// Packs LSB-first stream words into a CFG_W shadow; bits past CFG_W in the last word drop off.
module tile_cfg_shadow #(
  parameter int unsigned CFG_W  = 77,
  parameter int unsigned WORD_W = 8,
  parameter int unsigned WPT    = 10,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [CFG_W-1:0]  shadow_c
);

  logic [CFG_W-1:0] shadow_q, shadow_d, mask;

  always_comb begin
    mask = '0;
    for (int unsigned w = 0; w < WPT; w++) begin
      if (idx_i == IDX_W'(w)) mask = CFG_W'({WORD_W{1'b1}}) << (w * WORD_W);
    end
    shadow_d = shadow_q;
    if (we_i) shadow_d = (shadow_q & ~mask) | (CFG_W'({WPT{word_i}}) & mask);
    shadow_c = shadow_d;
    if (clr_i) shadow_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow_q <= '0;
    else        shadow_q <= shadow_d;
  end

endmodule

// File: rtl/tile_cfg_loader.sv
// Streams per-tile configuration frames and strobes each tile's write enable once its frame is complete.
module tile_cfg_loader
  import tile_cfg_pkg::*;
#(
  parameter int unsigned NUM_TILES = 4,
  parameter int unsigned CFG_W     = 77,
  parameter int unsigned WORD_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 s_valid,
  input  logic [WORD_W-1:0]    s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [NUM_TILES-1:0] wr_en,
  output logic [CFG_W-1:0]     bits,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned WPT    = ceil_div(CFG_W, WORD_W);
  localparam int unsigned WCNT_W = cnt_w(WPT);
  localparam int unsigned TCNT_W = cnt_w(NUM_TILES);

  state_e               state_q, state_d;
  logic [WCNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [TCNT_W-1:0]    tile_cnt_q, tile_cnt_d;
  logic                 s_ready_q, s_ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [NUM_TILES-1:0] wr_en_q, wr_en_d;
  logic [CFG_W-1:0]     bits_q, bits_d, shadow_c;
  logic                 shadow_clr, shadow_we, last_word, last_tile;

  assign last_word = (word_cnt_q == WCNT_W'(WPT - 1));
  assign last_tile = (tile_cnt_q == TCNT_W'(NUM_TILES - 1));

  tile_cfg_shadow #(
    .CFG_W  (CFG_W),
    .WORD_W (WORD_W),
    .WPT    (WPT),
    .IDX_W  (WCNT_W)
  ) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (shadow_clr),
    .we_i     (shadow_we),
    .idx_i    (word_cnt_q),
    .word_i   (s_data),
    .shadow_c (shadow_c)
  );

  // Next state, counters and shadow control; outputs are registered from the next state.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    tile_cnt_d = tile_cnt_q;
    bits_d     = bits_q;
    shadow_clr = 1'b0;
    shadow_we  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          word_cnt_d = '0;
          tile_cnt_d = '0;
          shadow_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        if (s_valid && s_ready_q) begin
          shadow_we = 1'b1;
          // s_last must mark exactly the final word of the final tile.
          if (s_last != (last_word && last_tile)) begin
            state_d = ST_ERR;
          end else if (last_word) begin
            state_d = ST_WRITE;
            bits_d  = shadow_c;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (last_tile) begin
          state_d = ST_DONE;
        end else begin
          state_d    = ST_LOAD;
          tile_cnt_d = tile_cnt_q + 1'b1;
          word_cnt_d = '0;
          shadow_clr = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      bits_d  = bits_q;
    end

    s_ready_d = (state_d == ST_LOAD);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    err_d     = (state_d == ST_ERR);
    wr_en_d   = '0;
    for (int unsigned t = 0; t < NUM_TILES; t++) begin
      wr_en_d[t] = (state_d == ST_WRITE) && (tile_cnt_d == TCNT_W'(t));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      tile_cnt_q <= '0;
      s_ready_q  <= 1'b0;
      wr_en_q    <= '0;
      bits_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      tile_cnt_q <= tile_cnt_d;
      s_ready_q  <= s_ready_d;
      wr_en_q    <= wr_en_d;
      bits_q     <= bits_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign s_ready = s_ready_q;
  assign wr_en   = wr_en_q;
  assign bits    = bits_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_tile_cfg_loader.sv
// Directed bench for tile_cfg_loader at default parameters (4 tiles, 77-bit frames, 8-bit words).
module tb_tile_cfg_loader;

  localparam int NT  = 4;
  localparam int CW  = 77;
  localparam int WW  = 8;
  localparam int WPT = 10;

  logic          clk, rst_n, start, abort, s_valid, s_last;
  logic [WW-1:0] s_data;
  logic          s_ready, busy, done, err;
  logic [NT-1:0] wr_en;
  logic [CW-1:0] bits;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_cyc  = 0;
  int hold_tile = -1;
  int wr_log[$];
  logic [CW-1:0] exp_frame [NT];

  tile_cfg_loader #(.NUM_TILES(NT), .CFG_W(CW), .WORD_W(WW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_ready (s_ready),
    .wr_en   (wr_en),
    .bits    (bits),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] word_val(input int t, input int w);
    if (t == 0 && w == WPT - 1) return 8'hFF;
    return 8'(t * 40 + w * 7 + 3);
  endfunction

  // Monitor: logs write strobes and checks the frame on the bus during and after each strobe.
  always @(negedge clk) begin
    if (hold_tile >= 0) chk("bits_hold", 128'(bits), 128'(exp_frame[hold_tile]));
    hold_tile = -1;
    if (done) done_cnt++;
    if (err) err_cyc++;
    if (wr_en != '0) begin
      chk("wr_onehot", 128'($countones(wr_en)), 128'(1));
      for (int t = 0; t < NT; t++) begin
        if (wr_en[t]) begin
          wr_log.push_back(t);
          hold_tile = t;
        end
      end
      chk("bits_frame", 128'(bits), 128'(exp_frame[hold_tile]));
      if (hold_tile == 0) chk("t0_top_bits", 128'(bits[76:72]), 128'(5'h1F));
    end
  end

  task automatic send_word(input logic [7:0] d, input logic last, input bit gap, input bit st);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    start   = st;
    for (int i = 0; i < 64; i++) begin
      if (s_ready) begin
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b0;
        if (gap) begin
          @(posedge clk); #1;
        end
        return;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout", 128'(0), 128'(1));
    s_valid = 1'b0;
    s_last  = 1'b0;
    start   = 1'b0;
  endtask

  // Sends global words [0, count); last_at marks s_last, start_at raises start alongside that word.
  task automatic send_range(input int count, input int last_at, input bit gap, input int start_at);
    for (int k = 0; k < count; k++) begin
      send_word(word_val(k / WPT, k % WPT), k == last_at, gap, k == start_at);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (!busy) return;
      @(posedge clk); #1;
    end
    chk("idle_timeout", 128'(busy), 128'(0));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic full_load(input string name, input bit gap, input int start_at);
    int base_w, base_d;
    base_w = wr_log.size();
    base_d = done_cnt;
    pulse_start();
    chk({name, "_ready"}, 128'(s_ready), 128'(1));
    chk({name, "_busy"}, 128'(busy), 128'(1));
    send_range(NT * WPT, NT * WPT - 1, gap, start_at);
    wait_idle();
    idle_cycles(2);
    chk({name, "_wr_count"}, 128'(wr_log.size() - base_w), 128'(NT));
    for (int t = 0; t < NT; t++) begin
      if (base_w + t < wr_log.size()) chk({name, "_wr_order"}, 128'(wr_log[base_w + t]), 128'(t));
    end
    chk({name, "_done_once"}, 128'(done_cnt - base_d), 128'(1));
    chk({name, "_err"}, 128'(err), 128'(0));
  endtask

  initial begin
    logic [79:0] f;
    int base_w, base_d, base_e;

    for (int t = 0; t < NT; t++) begin
      f = '0;
      for (int w = 0; w < WPT; w++) f[w*8 +: 8] = word_val(t, w);
      exp_frame[t] = f[CW-1:0];
    end

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    #3;
    chk("rst_ready", 128'(s_ready), 128'(0));
    chk("rst_wr_en", 128'(wr_en), 128'(0));
    chk("rst_bits", 128'(bits), 128'(0));
    chk("rst_flags", 128'({busy, done, err}), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // abort together with start in IDLE keeps the loader idle
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 128'(busy), 128'(0));

    full_load("cont", 1'b0, -1);
    full_load("stall", 1'b1, -1);
    full_load("restart_ign", 1'b0, 13);

    // Early s_last on word 15: error, only tile 0 written, abort clears it
    base_w = wr_log.size();
    base_e = err_cyc;
    pulse_start();
    send_range(15, 14, 1'b0, -1);
    chk("err_set", 128'(err), 128'(1));
    chk("err_ready", 128'(s_ready), 128'(0));
    idle_cycles(3);
    chk("err_sticky", 128'(err), 128'(1));
    chk("err_wr_count", 128'(wr_log.size() - base_w), 128'(1));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("err_clear", 128'({err, busy}), 128'(0));
    chk("err_seen", 128'(err_cyc > base_e), 128'(1));

    // Missing s_last on the very last word is also an error
    base_w = wr_log.size();
    pulse_start();
    send_range(NT * WPT, -1, 1'b0, -1);
    chk("nolast_err", 128'(err), 128'(1));
    chk("nolast_wr_count", 128'(wr_log.size() - base_w), 128'(NT - 1));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;

    // Abort during tile 2: tile 2 never written
    base_w = wr_log.size();
    base_d = done_cnt;
    pulse_start();
    send_range(2 * WPT + 5, -1, 1'b0, -1);
    s_valid = 1'b1; s_data = word_val(2, 5); abort = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; abort = 1'b0;
    chk("abort_idle", 128'({busy, s_ready}), 128'(0));
    idle_cycles(4);
    chk("abort_wr_count", 128'(wr_log.size() - base_w), 128'(2));
    chk("abort_no_done", 128'(done_cnt - base_d), 128'(0));

    // Reset during tile 1: outputs clear immediately, no further writes
    base_w = wr_log.size();
    pulse_start();
    send_range(WPT + 3, -1, 1'b0, -1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 128'(s_ready), 128'(0));
    chk("mid_rst_bits", 128'(bits), 128'(0));
    chk("mid_rst_flags", 128'({busy, done, err, wr_en}), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    idle_cycles(4);
    chk("mid_rst_idle", 128'(busy), 128'(0));
    chk("mid_rst_wr_count", 128'(wr_log.size() - base_w), 128'(1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
